ddr_rw_scheduler: RTL and testbench
===================================

# ddr_rw_scheduler

Direction scheduler sharing the single DDR3 AXI port between the write path (output of the multichannel write arbiter) and the read path (output of the multichannel read arbiter). It batches bursts of one direction to cut bus turnaround, inserts a fixed turnaround gap on each direction change, and bounds waiting time of the idle direction. It sits between the two channel arbiters and the AXI write/read masters.

## Interface
Parameters:
- ADDR_W, 30, DDR byte address width
- MAX_BATCH, 4, max consecutive bursts in one direction while the other direction is waiting (1..15)
- TURN_CYC, 2, idle cycles inserted on each direction change (0..7)
- STARVE_LIMIT, 256, wait cycles after which the waiting direction is forced next (1..1023)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- wr_req  in  1  write request, level, held until wr_grant
- wr_addr  in  ADDR_W  write burst address, valid while wr_req
- wr_len  in  8  write burst length (AXI AWLEN)
- wr_grant  out  1  one-cycle pulse, write request accepted
- rd_req  in  1  read request, level, held until rd_grant
- rd_addr  in  ADDR_W  read burst address
- rd_len  in  8  read burst length (AXI ARLEN)
- rd_grant  out  1  one-cycle pulse, read request accepted
- axi_wr_start  out  1  one-cycle start to AXI write master
- axi_wr_addr  out  ADDR_W  registered write address
- axi_wr_len  out  8  registered write length
- wr_done  in  1  AXI write master burst complete (BRESP received)
- axi_rd_start  out  1  one-cycle start to AXI read master
- axi_rd_addr  out  ADDR_W  registered read address
- axi_rd_len  out  8  registered read length
- rd_done  in  1  AXI read master burst complete (RLAST accepted)
- dir  out  1  current/last direction, 1 = write

## Operation
- States: IDLE, WR_WAIT, RD_WAIT, TURN.
- IDLE: only wr_req -> issue write; only rd_req -> issue read; both -> issue direction opposite to dir (dir resets to 0, so write wins first).
- Issue: registered start + grant pulse together; addr/len captured from request inputs in the same edge; batch_cnt increments; state -> WR_WAIT/RD_WAIT.
- WR_WAIT/RD_WAIT: hold until matching done; other done input ignored. On done decide:
  - switch if other req high and (batch_cnt == MAX_BATCH or starve flag set), or same req low and other req high;
  - else same req high -> reissue same direction immediately;
  - else -> IDLE.
- Switch: batch_cnt cleared, dir toggled, TURN for TURN_CYC cycles (skipped if 0), then issue other direction unconditionally (its req is held).
- batch_cnt saturates at MAX_BATCH; if other direction not requesting, same direction continues indefinitely.
- Starve counter: increments each cycle the non-current direction's req is high and not granted; saturates at STARVE_LIMIT; starve flag = (count == STARVE_LIMIT); cleared on grant to that direction.
- Requests arriving during TURN or WAIT only take effect at the next decision point.

## Timing
- Reset: all outputs 0, state IDLE, counters 0, dir 0. Reset mid-burst abandons it; a later done is ignored in IDLE.
- Request high at edge N in IDLE -> start/grant high cycle N+1 only.
- Done sampled at edge M, same direction -> next start cycle M+1; switch -> start cycle M+1+TURN_CYC.
- Requester must drop or update req the cycle after grant; req still high after grant = new request.
- axi_*_addr/len stable from start until next start of same direction.
- Never both starts in one cycle; at most one burst outstanding.

## Configuration
- RW_SCHED_STARVE_EN defined: starve counter and forced switch as above.
- Undefined: no starve counter; switching governed only by MAX_BATCH and request availability; STARVE_LIMIT unused.

## Test plan
- Reset, wr_req=1 addr 0x100 len 15 -> axi_wr_start/wr_grant 1 cycle after, axi_wr_addr=0x100, axi_wr_len=15, state WR_WAIT.
- Both reqs from reset, wr_done 20 cycles after each start, TURN_CYC=2 -> exactly 4 writes, then rd start 3 cycles after 4th wr_done, dir=0.
- Only writes, 10 back-to-back -> 10 starts each 1 cycle after wr_done, no TURN.
- Macro on, MAX_BATCH=15, STARVE_LIMIT=32, long writes (50 cycles each), rd_req waiting -> read issued after first write's done.
- Simultaneous wr_done and rd_done in RD_WAIT -> only rd_done acts; no spurious write start.
- rst_n asserted during WR_WAIT, then wr_done -> outputs 0, state IDLE, no start.

Source files
------------

// File: rtl/ddr_rw_scheduler.sv
// ddr_rw_scheduler: shares one DDR3 AXI port between the write and read
// arbiters. It batches bursts per direction, inserts a turnaround gap on
// every direction change and can bound the waiting time of the idle side.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_req/addr/len   write request (level, held until wr_grant)
//   wr_grant          one-cycle accept pulse for the write request
//   rd_req/addr/len   read request (level, held until rd_grant)
//   rd_grant          one-cycle accept pulse for the read request
//   axi_wr_*          registered start/addr/len to the AXI write master
//   wr_done           write burst complete (BRESP received)
//   axi_rd_*          registered start/addr/len to the AXI read master
//   rd_done           read burst complete (RLAST accepted)
//   dir               current/last direction, 1 = write
//
// Optional feature: define RW_SCHED_STARVE_EN to enable the starvation
// counters that force a direction switch after STARVE_LIMIT wait cycles.
module ddr_rw_scheduler #(
    parameter int ADDR_W       = 30,
    parameter int MAX_BATCH    = 4,
    parameter int TURN_CYC     = 2,
    parameter int STARVE_LIMIT = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_len,
    output logic              wr_grant,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_len,
    output logic              rd_grant,
    output logic              axi_wr_start,
    output logic [ADDR_W-1:0] axi_wr_addr,
    output logic [7:0]        axi_wr_len,
    input  logic              wr_done,
    output logic              axi_rd_start,
    output logic [ADDR_W-1:0] axi_rd_addr,
    output logic [7:0]        axi_rd_len,
    input  logic              rd_done,
    output logic              dir
);

    localparam int BW = 4;
    localparam int TW = 3;

    if (MAX_BATCH < 1 || MAX_BATCH > 15) begin : g_bad_batch
        $error("MAX_BATCH out of range 1..15");
    end
    if (TURN_CYC < 0 || TURN_CYC > 7) begin : g_bad_turn
        $error("TURN_CYC out of range 0..7");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 1023) begin : g_bad_starve
        $error("STARVE_LIMIT out of range 1..1023");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_WAIT = 2'd1,
        RD_WAIT = 2'd2,
        TURN    = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              dir_q, dir_d;
    logic [BW-1:0]     batch_cnt_q, batch_cnt_d;
    logic [TW-1:0]     turn_cnt_q, turn_cnt_d;
    logic              wr_start_q, wr_start_d;
    logic              rd_start_q, rd_start_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]        wr_len_q, wr_len_d;
    logic [7:0]        rd_len_q, rd_len_d;

    logic              issue_wr;
    logic              issue_rd;
    logic              switch_dir;
    logic              batch_full;
    logic [BW-1:0]     batch_bump;
    logic              wr_starve;
    logic              rd_starve;

    assign batch_full = (batch_cnt_q == BW'(MAX_BATCH));
    assign batch_bump = batch_full ? batch_cnt_q : batch_cnt_q + 1'b1;

`ifdef RW_SCHED_STARVE_EN
    localparam int SW = 10;

    logic [SW-1:0] wr_stv_q, wr_stv_d;
    logic [SW-1:0] rd_stv_q, rd_stv_d;

    assign wr_starve = (wr_stv_q == SW'(STARVE_LIMIT));
    assign rd_starve = (rd_stv_q == SW'(STARVE_LIMIT));

    // Only the side that is not the current direction accumulates wait.
    always_comb begin
        wr_stv_d = wr_stv_q;
        rd_stv_d = rd_stv_q;
        if (issue_wr) begin
            wr_stv_d = '0;
        end else if (wr_req && !dir_q && !wr_starve) begin
            wr_stv_d = wr_stv_q + 1'b1;
        end
        if (issue_rd) begin
            rd_stv_d = '0;
        end else if (rd_req && dir_q && !rd_starve) begin
            rd_stv_d = rd_stv_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_stv_q <= '0;
            rd_stv_q <= '0;
        end else begin
            wr_stv_q <= wr_stv_d;
            rd_stv_q <= rd_stv_d;
        end
    end
`else
    assign wr_starve = 1'b0;
    assign rd_starve = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        batch_cnt_d = batch_cnt_q;
        turn_cnt_d  = turn_cnt_q;
        wr_start_d  = 1'b0;
        rd_start_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        wr_len_d    = wr_len_q;
        rd_len_d    = rd_len_q;
        issue_wr    = 1'b0;
        issue_rd    = 1'b0;
        switch_dir  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // On contention serve the side opposite the last one.
                if (wr_req && rd_req) begin
                    issue_wr = ~dir_q;
                    issue_rd = dir_q;
                end else begin
                    issue_wr = wr_req;
                    issue_rd = rd_req;
                end
            end
            WR_WAIT: begin
                if (wr_done) begin
                    if (rd_req && (batch_full || rd_starve || !wr_req)) begin
                        switch_dir = 1'b1;
                    end else if (wr_req) begin
                        issue_wr = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RD_WAIT: begin
                if (rd_done) begin
                    if (wr_req && (batch_full || wr_starve || !rd_req)) begin
                        switch_dir = 1'b1;
                    end else if (rd_req) begin
                        issue_rd = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            TURN: begin
                // dir already points at the new side; its req is held.
                if (turn_cnt_q == '0) begin
                    issue_wr = dir_q;
                    issue_rd = ~dir_q;
                end else begin
                    turn_cnt_d = turn_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (switch_dir) begin
            batch_cnt_d = '0;
            dir_d       = ~dir_q;
            if (TURN_CYC == 0) begin
                issue_wr = ~dir_q;
                issue_rd = dir_q;
            end else begin
                state_d    = TURN;
                turn_cnt_d = TW'(TURN_CYC - 1);
            end
        end

        // A direction change restarts the batch count at the first burst.
        if (issue_wr) begin
            wr_start_d  = 1'b1;
            wr_addr_d   = wr_addr;
            wr_len_d    = wr_len;
            dir_d       = 1'b1;
            state_d     = WR_WAIT;
            batch_cnt_d = dir_q ? batch_bump : BW'(1);
        end
        if (issue_rd) begin
            rd_start_d  = 1'b1;
            rd_addr_d   = rd_addr;
            rd_len_d    = rd_len;
            dir_d       = 1'b0;
            state_d     = RD_WAIT;
            batch_cnt_d = !dir_q ? batch_bump : BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dir_q       <= 1'b0;
            batch_cnt_q <= '0;
            turn_cnt_q  <= '0;
            wr_start_q  <= 1'b0;
            rd_start_q  <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            wr_len_q    <= '0;
            rd_len_q    <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            batch_cnt_q <= batch_cnt_d;
            turn_cnt_q  <= turn_cnt_d;
            wr_start_q  <= wr_start_d;
            rd_start_q  <= rd_start_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            wr_len_q    <= wr_len_d;
            rd_len_q    <= rd_len_d;
        end
    end

    // Grant and start are the same registered pulse.
    assign wr_grant     = wr_start_q;
    assign rd_grant     = rd_start_q;
    assign axi_wr_start = wr_start_q;
    assign axi_rd_start = rd_start_q;
    assign axi_wr_addr  = wr_addr_q;
    assign axi_rd_addr  = rd_addr_q;
    assign axi_wr_len   = wr_len_q;
    assign axi_rd_len   = rd_len_q;
    assign dir          = dir_q;

endmodule

// File: tb/tb_ddr_rw_scheduler.sv
// tb_ddr_rw_scheduler: scoreboard bench for ddr_rw_scheduler.
// Main instance: MAX_BATCH=4, TURN_CYC=2; second: MAX_BATCH=15, TURN_CYC=0, STARVE_LIMIT=32.
module tb_ddr_rw_scheduler;

    localparam int AW   = 30;
    localparam int TURN = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic          wr_req, rd_req, wr_grant, rd_grant;
    logic [AW-1:0] wr_addr, rd_addr, axi_wr_addr, axi_rd_addr;
    logic [7:0]    wr_len, rd_len, axi_wr_len, axi_rd_len;
    logic          axi_wr_start, axi_rd_start, wr_done, rd_done, dir;

    // Requester model: a pending count; each grant consumes one request.
    int            wr_total = 0, wr_issued = 0, wr_first = 0;
    int            rd_total = 0, rd_issued = 0, rd_first = 0;
    logic [AW-1:0] wr_base = '0, rd_base = '0;
    logic [7:0]    wr_len0 = '0, rd_len0 = '0;

    assign wr_req  = (wr_issued < wr_total);
    assign rd_req  = (rd_issued < rd_total);
    assign wr_addr = wr_base + AW'((wr_issued - wr_first) * 64);
    assign rd_addr = rd_base + AW'((rd_issued - rd_first) * 64);
    assign wr_len  = wr_len0 + 8'(wr_issued - wr_first);
    assign rd_len  = rd_len0 + 8'(rd_issued - rd_first);

    always @(negedge clk) if (wr_grant) wr_issued <= wr_issued + 1;
    always @(negedge clk) if (rd_grant) rd_issued <= rd_issued + 1;

    // AXI master model: done a fixed number of cycles after start.
    bit   auto_en = 1'b1;
    int   wr_dly = 20, rd_dly = 5;
    int   wcnt = 0, rcnt = 0;
    int   wr_done_cyc = 0, rd_done_cyc = 0;
    logic auto_wr_done = 1'b0, auto_rd_done = 1'b0;
    logic man_wr_done = 1'b0, man_rd_done = 1'b0;

    assign wr_done = auto_wr_done | man_wr_done;
    assign rd_done = auto_rd_done | man_rd_done;

    always @(negedge clk) begin
        auto_wr_done <= 1'b0;
        if (!auto_en) wcnt <= 0;
        else if (axi_wr_start) wcnt <= wr_dly;
        else if (wcnt == 1) begin
            wcnt <= 0;
            auto_wr_done <= 1'b1;
            wr_done_cyc <= cyc;
        end else if (wcnt > 1) wcnt <= wcnt - 1;
    end

    always @(negedge clk) begin
        auto_rd_done <= 1'b0;
        if (!auto_en) rcnt <= 0;
        else if (axi_rd_start) rcnt <= rd_dly;
        else if (rcnt == 1) begin
            rcnt <= 0;
            auto_rd_done <= 1'b1;
            rd_done_cyc <= cyc;
        end else if (rcnt > 1) rcnt <= rcnt - 1;
    end

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        int            cyc;
        bit            dir;
        bit            gnt;
    } obs_t;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } exp_t;

    obs_t obs_q[$];
    exp_t exp_q[$];
    int   obs_idx = 0;
    int   both_cnt = 0;

    always @(negedge clk) begin
        if (axi_wr_start && axi_rd_start) both_cnt <= both_cnt + 1;
        if (axi_wr_start)
            obs_q.push_back('{1'b1, axi_wr_addr, axi_wr_len, cyc, dir, wr_grant && !rd_grant});
        else if (axi_rd_start)
            obs_q.push_back('{1'b0, axi_rd_addr, axi_rd_len, cyc, dir, rd_grant && !wr_grant});
    end

    ddr_rw_scheduler #(
        .ADDR_W(AW), .MAX_BATCH(4), .TURN_CYC(TURN), .STARVE_LIMIT(256)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_grant(wr_grant),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_grant(rd_grant),
        .axi_wr_start(axi_wr_start), .axi_wr_addr(axi_wr_addr), .axi_wr_len(axi_wr_len),
        .wr_done(wr_done),
        .axi_rd_start(axi_rd_start), .axi_rd_addr(axi_rd_addr), .axi_rd_len(axi_rd_len),
        .rd_done(rd_done), .dir(dir)
    );

    logic          s_wr_req = 1'b0, s_rd_req = 1'b0, s_wr_done = 1'b0, s_rd_done = 1'b0;
    logic [AW-1:0] s_wr_addr = '0, s_rd_addr = '0;
    logic [7:0]    s_wr_len = '0, s_rd_len = '0;
    logic          s_wr_grant, s_rd_grant, s_axi_wr_start, s_axi_rd_start, s_dir;
    logic [AW-1:0] s_axi_wr_addr, s_axi_rd_addr;
    logic [7:0]    s_axi_wr_len, s_axi_rd_len;

    ddr_rw_scheduler #(
        .ADDR_W(AW), .MAX_BATCH(15), .TURN_CYC(0), .STARVE_LIMIT(32)
    ) u_stv (
        .clk(clk), .rst_n(rst_n),
        .wr_req(s_wr_req), .wr_addr(s_wr_addr), .wr_len(s_wr_len), .wr_grant(s_wr_grant),
        .rd_req(s_rd_req), .rd_addr(s_rd_addr), .rd_len(s_rd_len), .rd_grant(s_rd_grant),
        .axi_wr_start(s_axi_wr_start), .axi_wr_addr(s_axi_wr_addr), .axi_wr_len(s_axi_wr_len),
        .wr_done(s_wr_done),
        .axi_rd_start(s_axi_rd_start), .axi_rd_addr(s_axi_rd_addr), .axi_rd_len(s_axi_rd_len),
        .rd_done(s_rd_done), .dir(s_dir)
    );

    task automatic get_obs(input int budget, output bit got, output obs_t o);
        got = 1'b0;
        o = '{1'b0, '0, '0, 0, 1'b0, 1'b0};
        repeat (budget) begin
            @(negedge clk);
            #1;
            if (obs_q.size() > obs_idx) begin
                o = obs_q[obs_idx];
                obs_idx++;
                got = 1'b1;
                return;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        auto_en = 1'b1;
        man_wr_done = 1'b0;
        man_rd_done = 1'b0;
        s_wr_req = 1'b0;
        s_rd_req = 1'b0;
        s_wr_done = 1'b0;
        repeat (3) @(negedge clk);
        wr_total = wr_issued;
        rd_total = rd_issued;
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.delete();
        obs_idx = obs_q.size();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (axi_wr_start !== 1'b0 || wr_grant !== 1'b0) begin failures++; $display("FAIL reset_wr_start got=%b/%b exp=0/0", axi_wr_start, wr_grant); end
        checks++; if (axi_rd_start !== 1'b0 || rd_grant !== 1'b0) begin failures++; $display("FAIL reset_rd_start got=%b/%b exp=0/0", axi_rd_start, rd_grant); end
        checks++; if (dir !== 1'b0) begin failures++; $display("FAIL reset_dir got=%b exp=0", dir); end
        checks++; if (axi_wr_addr !== '0 || axi_wr_len !== '0) begin failures++; $display("FAIL reset_wr_regs got=%0h/%0h exp=0/0", axi_wr_addr, axi_wr_len); end
        checks++; if (axi_rd_addr !== '0 || axi_rd_len !== '0) begin failures++; $display("FAIL reset_rd_regs got=%0h/%0h exp=0/0", axi_rd_addr, axi_rd_len); end
        checks++; if (dut.state_q !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dut.state_q); end
        apply_reset();
    endtask

    task automatic test_single_write();
        bit got;
        obs_t o;
        exp_t e;
        int c0;
        apply_reset();
        wr_dly = 5;
        wr_first = wr_issued; wr_base = 'h100; wr_len0 = 8'd15;
        exp_q.push_back('{1'b1, 30'h100, 8'd15});
        wr_total = wr_issued + 1;
        c0 = cyc;
        get_obs(10, got, o);
        e = exp_q.pop_front();
        checks++; if (!got) begin failures++; $display("FAIL single_timeout got=none exp=start"); return; end
        checks++; if (o.cyc !== c0 + 1) begin failures++; $display("FAIL single_cyc got=%0d exp=%0d", o.cyc, c0 + 1); end
        checks++; if (o.wr !== e.wr || o.gnt !== 1'b1) begin failures++; $display("FAIL single_kind got=%b/%b exp=1/1", o.wr, o.gnt); end
        checks++; if (o.addr !== e.addr) begin failures++; $display("FAIL single_addr got=%0h exp=%0h", o.addr, e.addr); end
        checks++; if (o.len !== e.len) begin failures++; $display("FAIL single_len got=%0d exp=%0d", o.len, e.len); end
        checks++; if (dut.state_q !== 2'd1) begin failures++; $display("FAIL single_state got=%0d exp=1", dut.state_q); end
        repeat (12) @(negedge clk);
        #1;
        checks++; if (dut.state_q !== 2'd0) begin failures++; $display("FAIL single_idle got=%0d exp=0", dut.state_q); end
        checks++; if (obs_q.size() !== obs_idx) begin failures++; $display("FAIL single_extra got=%0d exp=0", obs_q.size() - obs_idx); end
    endtask

    task automatic test_batch();
        bit got, prev_wr;
        obs_t o;
        exp_t e;
        int c0, exp_c, n;
        apply_reset();
        wr_dly = 20; rd_dly = 5;
        wr_first = wr_issued; wr_base = 'h4000; wr_len0 = 8'd7;
        rd_first = rd_issued; rd_base = 'h8000; rd_len0 = 8'd3;
        for (int i = 0; i < 4; i++) exp_q.push_back('{1'b1, AW'('h4000 + 64 * i), 8'(7 + i)});
        exp_q.push_back('{1'b0, 30'h8000, 8'd3});
        for (int i = 4; i < 6; i++) exp_q.push_back('{1'b1, AW'('h4000 + 64 * i), 8'(7 + i)});
        wr_total = wr_issued + 6;
        rd_total = rd_issued + 1;
        c0 = cyc;
        n = exp_q.size();
        prev_wr = 1'b0;
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            get_obs(60, got, o);
            checks++; if (!got) begin failures++; $display("FAIL batch_timeout[%0d] got=none exp=start", i); return; end
            if (i == 0) exp_c = c0 + 1;
            else exp_c = (prev_wr ? wr_done_cyc : rd_done_cyc) + 1 + ((e.wr != prev_wr) ? TURN : 0);
            checks++; if (o.wr !== e.wr) begin failures++; $display("FAIL batch_dir[%0d] got=%b exp=%b", i, o.wr, e.wr); end
            checks++; if (o.addr !== e.addr || o.len !== e.len) begin failures++; $display("FAIL batch_req[%0d] got=%0h/%0d exp=%0h/%0d", i, o.addr, o.len, e.addr, e.len); end
            checks++; if (o.cyc !== exp_c) begin failures++; $display("FAIL batch_cyc[%0d] got=%0d exp=%0d", i, o.cyc, exp_c); end
            checks++; if (o.dir !== e.wr || o.gnt !== 1'b1) begin failures++; $display("FAIL batch_dirout[%0d] got=%b/%b exp=%b/1", i, o.dir, o.gnt, e.wr); end
            prev_wr = e.wr;
        end
        repeat (30) @(negedge clk);
        #1;
        checks++; if (obs_q.size() !== obs_idx) begin failures++; $display("FAIL batch_extra got=%0d exp=0", obs_q.size() - obs_idx); end
    endtask

    task automatic test_back_to_back();
        bit got;
        obs_t o;
        exp_t e;
        int c0, exp_c;
        apply_reset();
        wr_dly = 3;
        wr_first = wr_issued; wr_base = 'h20000; wr_len0 = 8'd0;
        for (int i = 0; i < 10; i++) exp_q.push_back('{1'b1, AW'('h20000 + 64 * i), 8'(i)});
        wr_total = wr_issued + 10;
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            e = exp_q.pop_front();
            get_obs(20, got, o);
            checks++; if (!got) begin failures++; $display("FAIL b2b_timeout[%0d] got=none exp=start", i); return; end
            exp_c = (i == 0) ? c0 + 1 : wr_done_cyc + 1;
            checks++; if (o.wr !== e.wr || o.addr !== e.addr || o.len !== e.len) begin failures++; $display("FAIL b2b_req[%0d] got=%b/%0h/%0d exp=%b/%0h/%0d", i, o.wr, o.addr, o.len, e.wr, e.addr, e.len); end
            checks++; if (o.cyc !== exp_c) begin failures++; $display("FAIL b2b_cyc[%0d] got=%0d exp=%0d", i, o.cyc, exp_c); end
        end
        repeat (10) @(negedge clk);
        #1;
        checks++; if (dut.state_q !== 2'd0 || obs_q.size() !== obs_idx) begin failures++; $display("FAIL b2b_end got=%0d/%0d exp=0/0", dut.state_q, obs_q.size() - obs_idx); end
    endtask

    task automatic test_simul_done();
        bit got;
        obs_t o;
        int k;
        apply_reset();
        auto_en = 1'b0;
        rd_first = rd_issued; rd_base = 'h300; rd_len0 = 8'd1;
        wr_first = wr_issued; wr_base = 'h500; wr_len0 = 8'd2;
        exp_q.push_back('{1'b0, 30'h300, 8'd1});
        rd_total = rd_issued + 1;
        get_obs(5, got, o);
        checks++; if (!got || o.wr !== 1'b0) begin failures++; $display("FAIL simul_rd got=%b/%b exp=1/0", got, o.wr); return; end
        void'(exp_q.pop_front());
        exp_q.push_back('{1'b1, 30'h500, 8'd2});
        wr_total = wr_issued + 1;
        @(negedge clk);
        man_wr_done = 1'b1;
        @(negedge clk);
        man_wr_done = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        checks++; if (obs_q.size() !== obs_idx) begin failures++; $display("FAIL simul_stray got=%0d exp=0", obs_q.size() - obs_idx); end
        checks++; if (dut.state_q !== 2'd2) begin failures++; $display("FAIL simul_hold got=%0d exp=2", dut.state_q); end
        @(negedge clk);
        man_wr_done = 1'b1;
        man_rd_done = 1'b1;
        k = cyc;
        @(negedge clk);
        man_wr_done = 1'b0;
        man_rd_done = 1'b0;
        get_obs(8, got, o);
        checks++; if (!got) begin failures++; $display("FAIL simul_timeout got=none exp=start"); return; end
        checks++; if (o.wr !== 1'b1 || o.addr !== exp_q[0].addr || o.len !== exp_q[0].len) begin failures++; $display("FAIL simul_req got=%b/%0h exp=1/%0h", o.wr, o.addr, exp_q[0].addr); end
        checks++; if (o.cyc !== k + 1 + TURN) begin failures++; $display("FAIL simul_cyc got=%0d exp=%0d", o.cyc, k + 1 + TURN); end
        void'(exp_q.pop_front());
        repeat (5) @(negedge clk);
        #1;
        checks++; if (obs_q.size() !== obs_idx) begin failures++; $display("FAIL simul_extra got=%0d exp=0", obs_q.size() - obs_idx); end
    endtask

    task automatic test_reset_mid();
        bit got;
        obs_t o;
        apply_reset();
        auto_en = 1'b0;
        wr_first = wr_issued; wr_base = 'h700; wr_len0 = 8'd9;
        wr_total = wr_issued + 1;
        get_obs(5, got, o);
        checks++; if (!got || o.wr !== 1'b1) begin failures++; $display("FAIL rmid_start got=%b/%b exp=1/1", got, o.wr); end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (axi_wr_addr !== '0 || axi_wr_len !== '0 || dir !== 1'b0) begin failures++; $display("FAIL rmid_outs got=%0h/%0h/%b exp=0/0/0", axi_wr_addr, axi_wr_len, dir); end
        checks++; if (dut.state_q !== 2'd0) begin failures++; $display("FAIL rmid_state got=%0d exp=0", dut.state_q); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        obs_idx = obs_q.size();
        @(negedge clk);
        man_wr_done = 1'b1;
        @(negedge clk);
        man_wr_done = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        checks++; if (obs_q.size() !== obs_idx || dut.state_q !== 2'd0) begin failures++; $display("FAIL rmid_done got=%0d/%0d exp=0/0", obs_q.size() - obs_idx, dut.state_q); end
    endtask

    task automatic test_starve();
        bit got;
        apply_reset();
        auto_en = 1'b0;
        s_wr_addr = 'h2000; s_wr_len = 8'd3;
        s_rd_addr = 'h3000; s_rd_len = 8'd7;
        s_wr_req = 1'b1;
        s_rd_req = 1'b1;
        got = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (s_axi_wr_start || s_axi_rd_start) begin got = 1'b1; break; end
        end
        checks++; if (!got || s_axi_wr_start !== 1'b1) begin failures++; $display("FAIL starve_first got=%b/%b exp=1/1", got, s_axi_wr_start); return; end
        repeat (50) @(negedge clk);
        s_wr_done = 1'b1;
        @(negedge clk);
        s_wr_done = 1'b0;
        #1;
`ifdef RW_SCHED_STARVE_EN
        checks++; if (s_axi_rd_start !== 1'b1 || s_axi_wr_start !== 1'b0) begin failures++; $display("FAIL starve_switch got=rd%b/wr%b exp=rd1/wr0", s_axi_rd_start, s_axi_wr_start); end
        checks++; if (s_axi_rd_addr !== 30'h3000 || s_dir !== 1'b0) begin failures++; $display("FAIL starve_rd got=%0h/%b exp=3000/0", s_axi_rd_addr, s_dir); end
`else
        checks++; if (s_axi_wr_start !== 1'b1 || s_axi_rd_start !== 1'b0) begin failures++; $display("FAIL starve_stay got=wr%b/rd%b exp=wr1/rd0", s_axi_wr_start, s_axi_rd_start); end
        checks++; if (s_dir !== 1'b1) begin failures++; $display("FAIL starve_dir got=%b exp=1", s_dir); end
`endif
        s_wr_req = 1'b0;
        s_rd_req = 1'b0;
    endtask

    task automatic test_exclusive();
        checks++; if (both_cnt !== 0) begin failures++; $display("FAIL both_starts got=%0d exp=0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_batch();
        test_back_to_back();
        test_simul_done();
        test_reset_mid();
        test_starve();
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
